// File: rtl/hazard_forwarding_unit.sv
// Hazard and forwarding control for the 5-stage pipeline: tracks in-flight destinations
// in EX/MEM/WB and produces the decode bubble select, PC/IF-ID hold enables and forwarding selects.
module hazard_forwarding_unit #(
    parameter int REG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic [REG_W-1:0] id_rs,
    input  logic             id_use_rn,
    input  logic             id_use_rm,
    input  logic             id_use_rs,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_rf_we,
    input  logic             id_load,
    input  logic             flush,
    output logic             nop_select,
    output logic             pc_load,
    output logic             ifid_load,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [1:0]       fwd_s,
    output logic [CNT_W-1:0] stall_count
);

    typedef struct packed {
        logic             valid;
        logic             rf_we;
        logic             load;
        logic [REG_W-1:0] rd;
    } sb_entry_t;

    localparam logic [REG_W-1:0] PC_REG = REG_W'(15);
    localparam sb_entry_t        BUBBLE = '0;

    sb_entry_t ex_q, mem_q, wb_q;
    sb_entry_t id_entry;
    logic      load_use;
    logic      stall;

    // R15 reads the PC path, so it never participates in forwarding or stalls.
    function automatic logic src_match(input sb_entry_t e, input logic [REG_W-1:0] src,
                                       input logic use_src);
        return e.valid && e.rf_we && (e.rd == src) && use_src && (src != PC_REG);
    endfunction

    function automatic logic [1:0] fwd_sel(input sb_entry_t ex, input sb_entry_t mem,
                                           input sb_entry_t wb, input logic [REG_W-1:0] src,
                                           input logic use_src);
        logic [1:0] sel;
        sel = 2'b00;
        if (src_match(ex, src, use_src)) begin
            sel = ex.load ? 2'b00 : 2'b01;
        end else if (src_match(mem, src, use_src)) begin
            sel = 2'b10;
        end else if (src_match(wb, src, use_src)) begin
            sel = 2'b11;
        end
        return sel;
    endfunction

    assign id_entry = {1'b1, id_rf_we, id_load, id_rd};

    assign load_use = ex_q.load && (src_match(ex_q, id_rn, id_use_rn) ||
                                    src_match(ex_q, id_rm, id_use_rm) ||
                                    src_match(ex_q, id_rs, id_use_rs));

    assign stall = load_use && !flush;

    always_comb begin
        nop_select = 1'b0;
        pc_load    = 1'b1;
        ifid_load  = 1'b1;
        fwd_a      = 2'b00;
        fwd_b      = 2'b00;
        fwd_s      = 2'b00;
        if (!reset) begin
            fwd_a = fwd_sel(ex_q, mem_q, wb_q, id_rn, id_use_rn);
            fwd_b = fwd_sel(ex_q, mem_q, wb_q, id_rm, id_use_rm);
            fwd_s = fwd_sel(ex_q, mem_q, wb_q, id_rs, id_use_rs);
            if (flush) begin
                nop_select = 1'b1;
            end else if (load_use) begin
                nop_select = 1'b1;
                pc_load    = 1'b0;
                ifid_load  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q        <= BUBBLE;
            mem_q       <= BUBBLE;
            wb_q        <= BUBBLE;
            stall_count <= '0;
        end else begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            ex_q  <= nop_select ? BUBBLE : id_entry;
            if (stall && (stall_count != '1)) begin
                stall_count <= stall_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_forwarding_unit.sv
// Bench for hazard_forwarding_unit: a pipeline model checked every cycle, plus
// directed instruction sequences with hand-computed expectations.
module tb_hazard_forwarding_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  id_rn = '0, id_rm = '0, id_rs = '0, id_rd = '0;
    logic        id_use_rn = 1'b0, id_use_rm = 1'b0, id_use_rs = 1'b0;
    logic        id_rf_we = 1'b0, id_load = 1'b0, flush = 1'b0;
    logic        nop_select, pc_load, ifid_load;
    logic [1:0]  fwd_a, fwd_b, fwd_s;
    logic [15:0] stall_count;

    int n_checks = 0;
    int n_fail   = 0;

    hazard_forwarding_unit #(.REG_W(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .id_rn(id_rn), .id_rm(id_rm), .id_rs(id_rs),
        .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_use_rs(id_use_rs),
        .id_rd(id_rd), .id_rf_we(id_rf_we), .id_load(id_load), .flush(flush),
        .nop_select(nop_select), .pc_load(pc_load), .ifid_load(ifid_load),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_s(fwd_s), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    // Model pipeline: index 0 = EX, 1 = MEM, 2 = WB.
    int m_valid[3] = '{0, 0, 0};
    int m_we[3]    = '{0, 0, 0};
    int m_load[3]  = '{0, 0, 0};
    int m_rd[3]    = '{0, 0, 0};
    int m_count    = 0;

    function automatic int m_match(int k, int src, int u);
        return (m_valid[k] != 0 && m_we[k] != 0 && m_rd[k] == src && u != 0 && src != 15) ? 1 : 0;
    endfunction

    function automatic int m_fwd(int src, int u);
        if (m_match(0, src, u) != 0) return (m_load[0] != 0) ? 0 : 1;
        if (m_match(1, src, u) != 0) return 2;
        if (m_match(2, src, u) != 0) return 3;
        return 0;
    endfunction

    function automatic int m_load_use();
        if (m_load[0] == 0) return 0;
        return (m_match(0, int'(id_rn), int'(id_use_rn)) + m_match(0, int'(id_rm), int'(id_use_rm)) +
                m_match(0, int'(id_rs), int'(id_use_rs))) != 0 ? 1 : 0;
    endfunction

    function automatic int m_nop();
        if (reset) return 0;
        if (flush) return 1;
        return m_load_use();
    endfunction

    function automatic int m_hold();
        if (reset || flush) return 0;
        return m_load_use();
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 3; k++) begin
                m_valid[k] = 0; m_we[k] = 0; m_load[k] = 0; m_rd[k] = 0;
            end
            m_count = 0;
        end else begin
            int bubble;
            bubble = m_nop();
            if (m_hold() != 0 && m_count < 65535) m_count++;
            for (int k = 2; k > 0; k--) begin
                m_valid[k] = m_valid[k-1]; m_we[k] = m_we[k-1];
                m_load[k]  = m_load[k-1];  m_rd[k] = m_rd[k-1];
            end
            m_valid[0] = bubble ? 0 : 1;
            m_we[0]    = bubble ? 0 : int'(id_rf_we);
            m_load[0]  = bubble ? 0 : int'(id_load);
            m_rd[0]    = bubble ? 0 : int'(id_rd);
        end
    end

    // Outputs are meaningful every cycle, including during reset.
    always @(negedge clk) begin
        chk("model_nop_select", int'(nop_select), m_nop());
        chk("model_pc_load", int'(pc_load), 1 - m_hold());
        chk("model_ifid_load", int'(ifid_load), 1 - m_hold());
        chk("model_fwd_a", int'(fwd_a), reset ? 0 : m_fwd(int'(id_rn), int'(id_use_rn)));
        chk("model_fwd_b", int'(fwd_b), reset ? 0 : m_fwd(int'(id_rm), int'(id_use_rm)));
        chk("model_fwd_s", int'(fwd_s), reset ? 0 : m_fwd(int'(id_rs), int'(id_use_rs)));
        chk("model_stall_count", int'(stall_count), m_count);
    end

    // One ID-stage cycle: inputs applied just after the rising edge, returns at the falling edge.
    task automatic issue(input int rn, input int un, input int rm, input int um,
                         input int rs, input int us, input int rd, input int we,
                         input int ld, input int fl, input int rst);
        @(posedge clk);
        #1;
        id_rn = 4'(rn); id_use_rn = un[0];
        id_rm = 4'(rm); id_use_rm = um[0];
        id_rs = 4'(rs); id_use_rs = us[0];
        id_rd = 4'(rd); id_rf_we = we[0]; id_load = ld[0];
        flush = fl[0]; reset = rst[0];
        @(negedge clk);
    endtask

    task automatic nop_instr();
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        // Reset held two cycles with random instruction fields.
        for (int i = 0; i < 2; i++) begin
            issue($urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 15),
                  $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 1),
                  $urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 1), 1);
            chk("rst_nop_select", int'(nop_select), 0);
            chk("rst_pc_load", int'(pc_load), 1);
        end

        // ALU chain distance 0..3.
        issue(4, 1, 5, 1, 0, 0, 1, 1, 0, 0, 0);          // ADD R1
        chk("post_rst_fwd_a", int'(fwd_a), 0);
        chk("post_rst_stall_count", int'(stall_count), 0);
        chk("post_rst_nop", int'(nop_select), 0);
        issue(1, 1, 0, 0, 0, 0, 6, 1, 0, 0, 0);          // SUB Rn=R1
        chk("alu_ex_fwd_a", int'(fwd_a), 1);
        issue(0, 0, 0, 0, 0, 0, 7, 1, 0, 0, 0);          // ADD R7
        nop_instr();
        issue(7, 1, 0, 0, 0, 0, 6, 1, 0, 0, 0);
        chk("alu_mem_fwd_a", int'(fwd_a), 2);
        issue(0, 0, 0, 0, 0, 0, 8, 1, 0, 0, 0);          // ADD R8
        nop_instr(); nop_instr();
        issue(8, 1, 0, 0, 0, 0, 6, 1, 0, 0, 0);
        chk("alu_wb_fwd_a", int'(fwd_a), 3);
        issue(0, 0, 0, 0, 0, 0, 9, 1, 0, 0, 0);          // ADD R9
        nop_instr(); nop_instr(); nop_instr();
        issue(9, 1, 0, 0, 0, 0, 6, 1, 0, 0, 0);
        chk("alu_far_fwd_a", int'(fwd_a), 0);

        // Load-use: one stall cycle, then forward from MEM.
        issue(10, 1, 0, 0, 0, 0, 2, 1, 1, 0, 0);         // LDR R2
        issue(0, 0, 2, 1, 0, 0, 11, 1, 0, 0, 0);         // ADD Rm=R2
        chk("lu_nop_select", int'(nop_select), 1);
        chk("lu_pc_load", int'(pc_load), 0);
        chk("lu_ifid_load", int'(ifid_load), 0);
        issue(0, 0, 2, 1, 0, 0, 11, 1, 0, 0, 0);         // same ADD held in ID
        chk("lu_after_nop", int'(nop_select), 0);
        chk("lu_after_fwd_b", int'(fwd_b), 2);
        chk("lu_after_count", int'(stall_count), 1);

        // Back-to-back loads each stall once.
        issue(13, 1, 0, 0, 0, 0, 12, 1, 1, 0, 0);        // LDR R12
        issue(12, 1, 0, 0, 0, 0, 13, 1, 1, 0, 0);        // LDR R13, [R12]
        chk("b2b_stall1", int'(nop_select), 1);
        issue(12, 1, 0, 0, 0, 0, 13, 1, 1, 0, 0);
        chk("b2b_fwd_a", int'(fwd_a), 2);
        issue(0, 0, 13, 1, 0, 0, 11, 1, 0, 0, 0);        // ADD Rm=R13
        chk("b2b_stall2", int'(pc_load), 0);
        issue(0, 0, 13, 1, 0, 0, 11, 1, 0, 0, 0);
        chk("b2b_fwd_b", int'(fwd_b), 2);
        chk("b2b_count", int'(stall_count), 3);

        // Priority: R3 written in EX, MEM and WB.
        issue(0, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0);
        issue(0, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0);
        issue(0, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0);
        issue(0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0);          // STR Rs=R3
        chk("prio_fwd_s", int'(fwd_s), 1);

        // R15 never forwards nor stalls.
        issue(0, 0, 0, 0, 0, 0, 15, 1, 1, 0, 0);         // LDR R15
        issue(15, 1, 15, 1, 15, 1, 6, 1, 0, 0, 0);
        chk("r15_nop", int'(nop_select), 0);
        chk("r15_fwd_a", int'(fwd_a), 0);
        chk("r15_fwd_s", int'(fwd_s), 0);

        // Flush overrides a load-use hazard.
        issue(0, 0, 0, 0, 0, 0, 2, 1, 1, 0, 0);          // LDR R2
        issue(0, 0, 2, 1, 0, 0, 11, 1, 0, 1, 0);         // ADD Rm=R2 with flush
        chk("flush_nop", int'(nop_select), 1);
        chk("flush_pc_load", int'(pc_load), 1);
        chk("flush_ifid_load", int'(ifid_load), 1);
        issue(11, 1, 2, 1, 0, 0, 6, 0, 0, 0, 0);         // EX must hold a bubble
        chk("flush_count", int'(stall_count), 3);
        chk("flush_ex_bubble_fwd_a", int'(fwd_a), 0);
        chk("flush_mem_fwd_b", int'(fwd_b), 2);
        chk("flush_no_stall", int'(nop_select), 0);

        // Reset asserted during a stall cycle.
        issue(0, 0, 0, 0, 0, 0, 5, 1, 1, 0, 0);          // LDR R5
        issue(0, 0, 5, 1, 0, 0, 11, 1, 0, 0, 0);
        chk("pre_rst_stall", int'(nop_select), 1);
        issue(0, 0, 5, 1, 0, 0, 11, 1, 0, 0, 1);
        chk("mid_rst_nop", int'(nop_select), 0);
        chk("mid_rst_pc_load", int'(pc_load), 1);
        issue(0, 0, 5, 1, 0, 0, 11, 1, 0, 0, 0);
        chk("after_rst_fwd_b", int'(fwd_b), 0);
        chk("after_rst_nop", int'(nop_select), 0);
        chk("after_rst_count", int'(stall_count), 0);

        nop_instr();
        @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
